// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: pipelined SIMD ALU with scalar, 8-bit-lane and 16-bit-lane
// modes. Non-multiply ops complete in one cycle. Mul-low runs a lane-parallel
// shift-add sequence, one step per clock, for L steps.
// Optional feature macro: SIMD_ALU_SAT_EN builds the signed saturating
// add/sub (ops 1010/1011). Without it those ops decode as illegal.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | can accept; out_valid may still hold the last one-cycle result
// MUL   | shift-add multiply in progress; in_ready held low
// HOLD  | result presented and waiting for out_ready

module simd_alu_pipe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [5:0]      alu_ctrl,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SW  = $clog2(XLEN);
   localparam int N8  = XLEN / 8;
   localparam int N16 = XLEN / 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [1:0]      mode;
   logic [3:0]      op;
   logic            op_illegal;
   logic            op_is_mul;

   logic [XLEN-1:0] sc_res;
   logic [XLEN-1:0] l8_res;
   logic [XLEN-1:0] l16_res;
   logic [XLEN-1:0] alu_res;
   logic [SW-1:0]   sc_sh;
   logic [7:0]      l8_a, l8_b;
   logic [15:0]     l16_a, l16_b;

   logic [XLEN-1:0] mul_mcand, mul_mplier, mul_acc;
   logic [XLEN-1:0] mul_mcand_n, mul_mplier_n, mul_acc_n;
   logic [1:0]      mul_mode;
   logic [SW-1:0]   mul_cnt;
   logic [SW-1:0]   mul_len_m1;

   logic            fire;
   logic            load_alu;
   logic            start_mul;
   logic            mul_done;
   logic            clr_valid;

   assign mode = alu_ctrl[5:4];
   assign op   = alu_ctrl[3:0];

`ifdef SIMD_ALU_SAT_EN
   // Overflow in the extended sum shows up as a mismatch of the top two bits;
   // the clamp value is the true sign followed by its complement.
   function automatic logic [7:0] sat8(input logic [8:0] s);
      return (s[8] != s[7]) ? {s[8], {7{~s[8]}}} : s[7:0];
   endfunction

   function automatic logic [15:0] sat16(input logic [16:0] s);
      return (s[16] != s[15]) ? {s[16], {15{~s[16]}}} : s[15:0];
   endfunction

   function automatic logic [XLEN-1:0] satx(input logic [XLEN:0] s);
      return (s[XLEN] != s[XLEN-1]) ? {s[XLEN], {(XLEN-1){~s[XLEN]}}} : s[XLEN-1:0];
   endfunction
`endif

   // Decode mode/op legality; pass-b is scalar only.
   always_comb begin
      op_illegal = 1'b0;
      if (mode == 2'b11)
         op_illegal = 1'b1;
      else if (op[3:2] == 2'b11)
         op_illegal = 1'b1;
      else if ((op == 4'b1000) && (mode != 2'b00))
         op_illegal = 1'b1;
`ifndef SIMD_ALU_SAT_EN
      else if ((op == 4'b1010) || (op == 4'b1011))
         op_illegal = 1'b1;
`endif
      op_is_mul = (op == 4'b1001) && !op_illegal;
   end

   // Scalar (full-width) single-cycle ops.
   always_comb begin
      sc_sh  = b[SW-1:0];
      sc_res = '0;
      case (op)
         4'b0000: sc_res = a + b;
         4'b0001: sc_res = a - b;
         4'b0010: sc_res = a & b;
         4'b0011: sc_res = a | b;
         4'b0100: sc_res = a ^ b;
         4'b0101: sc_res = a << sc_sh;
         4'b0110: sc_res = a >> sc_sh;
         4'b0111: sc_res = XLEN'($signed(a) >>> sc_sh);
         4'b1000: sc_res = b;
`ifdef SIMD_ALU_SAT_EN
         4'b1010: sc_res = satx({a[XLEN-1], a} + {b[XLEN-1], b});
         4'b1011: sc_res = satx({a[XLEN-1], a} - {b[XLEN-1], b});
`endif
         default: sc_res = '0;
      endcase
   end

   // 8-bit lane ops; each lane is computed at its own width so nothing crosses.
   always_comb begin
      l8_res = '0;
      l8_a   = '0;
      l8_b   = '0;
      for (int i = 0; i < N8; i++) begin
         l8_a = a[8*i +: 8];
         l8_b = b[8*i +: 8];
         case (op)
            4'b0000: l8_res[8*i +: 8] = l8_a + l8_b;
            4'b0001: l8_res[8*i +: 8] = l8_a - l8_b;
            4'b0010: l8_res[8*i +: 8] = l8_a & l8_b;
            4'b0011: l8_res[8*i +: 8] = l8_a | l8_b;
            4'b0100: l8_res[8*i +: 8] = l8_a ^ l8_b;
            4'b0101: l8_res[8*i +: 8] = l8_a << l8_b[2:0];
            4'b0110: l8_res[8*i +: 8] = l8_a >> l8_b[2:0];
            4'b0111: l8_res[8*i +: 8] = 8'($signed(l8_a) >>> l8_b[2:0]);
`ifdef SIMD_ALU_SAT_EN
            4'b1010: l8_res[8*i +: 8] = sat8({l8_a[7], l8_a} + {l8_b[7], l8_b});
            4'b1011: l8_res[8*i +: 8] = sat8({l8_a[7], l8_a} - {l8_b[7], l8_b});
`endif
            default: l8_res[8*i +: 8] = 8'h00;
         endcase
      end
   end

   // 16-bit lane ops.
   always_comb begin
      l16_res = '0;
      l16_a   = '0;
      l16_b   = '0;
      for (int i = 0; i < N16; i++) begin
         l16_a = a[16*i +: 16];
         l16_b = b[16*i +: 16];
         case (op)
            4'b0000: l16_res[16*i +: 16] = l16_a + l16_b;
            4'b0001: l16_res[16*i +: 16] = l16_a - l16_b;
            4'b0010: l16_res[16*i +: 16] = l16_a & l16_b;
            4'b0011: l16_res[16*i +: 16] = l16_a | l16_b;
            4'b0100: l16_res[16*i +: 16] = l16_a ^ l16_b;
            4'b0101: l16_res[16*i +: 16] = l16_a << l16_b[3:0];
            4'b0110: l16_res[16*i +: 16] = l16_a >> l16_b[3:0];
            4'b0111: l16_res[16*i +: 16] = 16'($signed(l16_a) >>> l16_b[3:0]);
`ifdef SIMD_ALU_SAT_EN
            4'b1010: l16_res[16*i +: 16] = sat16({l16_a[15], l16_a} + {l16_b[15], l16_b});
            4'b1011: l16_res[16*i +: 16] = sat16({l16_a[15], l16_a} - {l16_b[15], l16_b});
`endif
            default: l16_res[16*i +: 16] = 16'h0000;
         endcase
      end
   end

   // Select the lane-mode result; illegal requests produce zero.
   always_comb begin
      alu_res = '0;
      if (!op_illegal) begin
         case (mode)
            2'b01:   alu_res = l8_res;
            2'b10:   alu_res = l16_res;
            default: alu_res = sc_res;
         endcase
      end
   end

   // Step count minus one, loaded into the multiply down-counter.
   always_comb begin
      case (mode)
         2'b01:   mul_len_m1 = SW'(7);
         2'b10:   mul_len_m1 = SW'(15);
         default: mul_len_m1 = SW'(XLEN - 1);
      endcase
   end

   // One shift-add step over every lane: add the multiplicand where the
   // lane's multiplier LSB is set, then shift both inside the lane.
   always_comb begin
      mul_acc_n    = mul_acc;
      mul_mcand_n  = mul_mcand;
      mul_mplier_n = mul_mplier;
      case (mul_mode)
         2'b01: begin
            for (int i = 0; i < N8; i++) begin
               mul_acc_n[8*i +: 8]    = mul_acc[8*i +: 8] +
                                        (mul_mplier[8*i] ? mul_mcand[8*i +: 8] : 8'h00);
               mul_mcand_n[8*i +: 8]  = {mul_mcand[8*i +: 7], 1'b0};
               mul_mplier_n[8*i +: 8] = {1'b0, mul_mplier[8*i+1 +: 7]};
            end
         end
         2'b10: begin
            for (int i = 0; i < N16; i++) begin
               mul_acc_n[16*i +: 16]    = mul_acc[16*i +: 16] +
                                          (mul_mplier[16*i] ? mul_mcand[16*i +: 16] : 16'h0000);
               mul_mcand_n[16*i +: 16]  = {mul_mcand[16*i +: 15], 1'b0};
               mul_mplier_n[16*i +: 16] = {1'b0, mul_mplier[16*i+1 +: 15]};
            end
         end
         default: begin
            mul_acc_n    = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
            mul_mcand_n  = {mul_mcand[XLEN-2:0], 1'b0};
            mul_mplier_n = {1'b0, mul_mplier[XLEN-1:1]};
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state and handshake strobes.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      fire      = 1'b0;
      load_alu  = 1'b0;
      start_mul = 1'b0;
      mul_done  = 1'b0;
      clr_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready  = !out_valid || out_ready;
            fire      = in_valid && in_ready;
            load_alu  = fire && !op_is_mul;
            start_mul = fire && op_is_mul;
            clr_valid = out_valid && out_ready && !fire;
            if (start_mul)
               state_d = MUL;
            else if (!fire && out_valid && !out_ready)
               state_d = HOLD;
         end
         MUL: begin
            mul_done = (mul_cnt == '0);
            if (mul_done)
               state_d = HOLD;
         end
         HOLD: begin
            clr_valid = out_ready;
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Result, flags, valid and multiplier registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result     <= '0;
         zero       <= 1'b1;
         illegal    <= 1'b0;
         out_valid  <= 1'b0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
         mul_acc    <= '0;
         mul_mode   <= 2'b00;
         mul_cnt    <= '0;
      end else begin
         if (load_alu) begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            illegal   <= op_illegal;
            out_valid <= 1'b1;
         end else if (start_mul) begin
            mul_mcand  <= a;
            mul_mplier <= b;
            mul_acc    <= '0;
            mul_mode   <= mode;
            mul_cnt    <= mul_len_m1;
            out_valid  <= 1'b0;
         end else if (state_q == MUL) begin
            mul_acc    <= mul_acc_n;
            mul_mcand  <= mul_mcand_n;
            mul_mplier <= mul_mplier_n;
            if (mul_done) begin
               result    <= mul_acc_n;
               zero      <= (mul_acc_n == '0);
               illegal   <= 1'b0;
               out_valid <= 1'b1;
            end else begin
               mul_cnt <= mul_cnt - SW'(1);
            end
         end else if (clr_valid) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Bench for simd_alu_pipe: scoreboard of expected results pushed on each
// accepted request and popped on each output handshake. Honours
// SIMD_ALU_SAT_EN to pick the expected behaviour of ops 1010/1011.

module tb_simd_alu_pipe;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        ill;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [5:0]  ctrl_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   exp_t sb[$];
   exp_t dir_exp;
   bit   dir_on;
   int   n_chk;
   int   n_fail;

   simd_alu_pipe #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .alu_ctrl  (ctrl_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: each lane extracted at width L and evaluated in 64-bit math.
   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic [5:0] c);
      exp_t   e;
      int     md, opc, lw, sh;
      bit     sat_en, ill;
      longint x, y, sx, sy, z, r, mask, lo, hi;
`ifdef SIMD_ALU_SAT_EN
      sat_en = 1'b1;
`else
      sat_en = 1'b0;
`endif
      md  = int'(c[5:4]);
      opc = int'(c[3:0]);
      ill = (md == 3) || (opc >= 12) || (opc == 8 && md != 0) ||
            (!sat_en && (opc == 10 || opc == 11));
      e.res  = 32'h0;
      e.zero = 1'b1;
      e.ill  = ill;
      if (ill) return e;
      lw   = (md == 0) ? 32 : (md == 1) ? 8 : 16;
      mask = (longint'(1) << lw) - 1;
      lo   = -(longint'(1) << (lw - 1));
      hi   = (longint'(1) << (lw - 1)) - 1;
      r    = 0;
      for (int i = 0; i < 32 / lw; i++) begin
         x  = (longint'(av) >> (i * lw)) & mask;
         y  = (longint'(bv) >> (i * lw)) & mask;
         sx = ((x >> (lw - 1)) & 1) != 0 ? x - (longint'(1) << lw) : x;
         sy = ((y >> (lw - 1)) & 1) != 0 ? y - (longint'(1) << lw) : y;
         sh = int'(y & longint'(lw - 1));
         case (opc)
            0:  z = x + y;
            1:  z = x - y;
            2:  z = x & y;
            3:  z = x | y;
            4:  z = x ^ y;
            5:  z = x << sh;
            6:  z = x >> sh;
            7:  z = sx >>> sh;
            8:  z = y;
            9:  z = x * y;
            10: begin z = sx + sy; if (z > hi) z = hi; if (z < lo) z = lo; end
            11: begin z = sx - sy; if (z > hi) z = hi; if (z < lo) z = lo; end
            default: z = 0;
         endcase
         r = r | ((z & mask) << (i * lw));
      end
      e.res  = r[31:0];
      e.zero = (r[31:0] == 32'h0);
      return e;
   endfunction

   task automatic pop_check();
      exp_t e;
      check_val("sb_depth", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_val("result", 64'(result), 64'(e.res));
         check_val("zero", 64'(zero), 64'(e.zero));
         check_val("illegal", 64'(illegal), 64'(e.ill));
      end
   endtask

   // Called just after a falling edge with inputs already set; returns just
   // after the next falling edge.
   task automatic tick();
      #1;
      if (out_valid && out_ready) pop_check();
      if (in_valid && in_ready) sb.push_back(dir_on ? dir_exp : model(a_i, b_i, ctrl_i));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_dir(input logic [31:0] r, input logic z, input logic il);
      dir_exp.res  = r;
      dir_exp.zero = z;
      dir_exp.ill  = il;
      dir_on       = 1'b1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 100 && (sb.size() != 0 || out_valid); k++) tick();
      check_val("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int n;
      int seen;
      n_chk     = 0;
      n_fail    = 0;
      dir_on    = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a_i       = '0;
      b_i       = '0;
      ctrl_i    = '0;
      out_ready = 1'b0;
      dir_exp   = '0;

      #23;
      check_val("rst_valid", 64'(out_valid), 64'd0);
      check_val("rst_result", 64'(result), 64'd0);
      check_val("rst_zero", 64'(zero), 64'd1);
      check_val("rst_illegal", 64'(illegal), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      // Mode 01 add, latency 1.
      out_ready = 1'b1;
      a_i = 32'h7F80FF01; b_i = 32'h01800102; ctrl_i = 6'b01_0000;
      set_dir(32'h80000003, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      dir_on = 1'b0;
      in_valid = 1'b0;
      check_val("add8_lat1_valid", 64'(out_valid), 64'd1);
      tick();

      // Mode 11 is illegal, still completes with latency 1.
      a_i = 32'h12345678; b_i = 32'h11111111; ctrl_i = 6'b11_0000;
      set_dir(32'h0, 1'b1, 1'b1);
      in_valid = 1'b1;
      tick();
      dir_on = 1'b0;
      in_valid = 1'b0;
      check_val("ill_lat1_valid", 64'(out_valid), 64'd1);
      tick();

      // Mode 01 saturating add.
      a_i = 32'h7F80107F; b_i = 32'h01FF1001; ctrl_i = 6'b01_1010;
`ifdef SIMD_ALU_SAT_EN
      set_dir(32'h7F80207F, 1'b0, 1'b0);
`else
      set_dir(32'h0, 1'b1, 1'b1);
`endif
      in_valid = 1'b1;
      tick();
      dir_on = 1'b0;
      in_valid = 1'b0;
      tick();

      // Mode 10 mul-low: 16 cycles busy, operand churn ignored meanwhile.
      a_i = 32'h00030100; b_i = 32'h00050100; ctrl_i = 6'b10_1001;
      set_dir(32'h000F0000, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      dir_on = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         check_val("mul_in_ready_low", 64'(in_ready), 64'd0);
         a_i = $urandom; b_i = $urandom; ctrl_i = 6'($urandom_range(0, 63));
         tick();
         n++;
      end
      check_val("mul16_latency", 64'(n), 64'd16);
      check_val("mul16_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      tick();

      // Scalar sub to zero, held for 5 cycles with out_ready low.
      out_ready = 1'b0;
      a_i = 32'h12345678; b_i = 32'h12345678; ctrl_i = 6'b00_0001;
      set_dir(32'h0, 1'b1, 1'b0);
      in_valid = 1'b1;
      tick();
      dir_on = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check_val("hold_valid", 64'(out_valid), 64'd1);
         check_val("hold_result", 64'(result), 64'd0);
         check_val("hold_zero", 64'(zero), 64'd1);
         check_val("hold_in_ready", 64'(in_ready), 64'd0);
         a_i = $urandom; b_i = $urandom; ctrl_i = 6'($urandom_range(0, 8));
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check_val("hold_released", 64'(out_valid), 64'd0);

      // Back-to-back single-cycle ops sustain one per cycle.
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         a_i = $urandom; b_i = $urandom;
         ctrl_i = {2'($urandom_range(0, 2)), 4'($urandom_range(0, 8))};
         #1;
         check_val("b2b_in_ready", 64'(in_ready), 64'd1);
         tick();
      end
      drain();

      // Random mix of everything, including illegal codes and stalls.
      for (int k = 0; k < 120; k++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         a_i = $urandom; b_i = $urandom;
         if ($urandom_range(0, 3) == 0) b_i = b_i & 32'h0F0F0F0F;
         ctrl_i = 6'($urandom_range(0, 63));
         tick();
      end
      drain();

      // Reset in the middle of a scalar multiply discards it.
      out_ready = 1'b1;
      a_i = 32'h00001234; b_i = 32'h00000567; ctrl_i = 6'b00_1001;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mulrst_valid", 64'(out_valid), 64'd0);
      check_val("mulrst_result", 64'(result), 64'd0);
      check_val("mulrst_zero", 64'(zero), 64'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("mulrst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) seen++;
         tick();
      end
      check_val("mulrst_no_output", 64'(seen), 64'd0);
      check_val("mulrst_result_after", 64'(result), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/simd_alu_pipe.md
SIMD_ALU_PIPE -- requirements
Module: simd_alu_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a multiple of 32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 a  input  XLEN  operand A.
REQ-007 b  input  XLEN  operand B.
REQ-008 alu_ctrl  input  6  [5:4] mode (00 scalar, 01 8-bit lanes, 10 16-bit lanes), [3:0] op.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  XLEN  registered result.
REQ-012 zero  output  1  registered, high when result == 0.
REQ-013 illegal  output  1  registered, high when the accepted mode/op is unsupported.

Function
REQ-014 Lane width L: XLEN in scalar mode, 8 in mode 01, 16 in mode 10; every lane computes independently; no carry, borrow or shift crosses a lane boundary.
REQ-015 Ops: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 pass-b (scalar only), 1001 mul-low, 1010 signed saturating add, 1011 signed saturating sub.
REQ-016 Add/sub/mul-low SHALL wrap modulo 2^L per lane.
REQ-017 Shift amount per lane SHALL be that lane's b low log2(L) bits.
REQ-018 Mode 11, op 1000 in a lane mode, or ops 1100-1111 SHALL be illegal: result 0, zero 1, illegal 1; the handshake still completes.
REQ-019 FSM states: IDLE, MUL, HOLD.
REQ-020 in_ready SHALL be high only in IDLE with out_valid low or out_ready high.
REQ-021 Transfer occurs on an edge where in_valid and in_ready are both high.
REQ-022 Non-multiply op: result, zero and illegal load on the accepting edge; out_valid is high from that edge (latency 1); FSM goes to HOLD unless out_ready is high on the following edge.
REQ-023 Mul-low: the accepting edge loads the operands and enters MUL; one shift-add step per edge over all lanes in parallel; after L steps, result loads, out_valid rises and the FSM enters HOLD; in_ready is low throughout MUL.
REQ-024 HOLD: result, zero, illegal and out_valid SHALL stay stable until an edge with out_ready high, which clears out_valid (or reloads it if a new transfer occurs on the same edge).
REQ-025 Back-to-back non-multiply ops with out_ready held high SHALL sustain one result per cycle.
REQ-026 Operand or alu_ctrl changes while in_ready is low SHALL have no effect.

Reset
REQ-027 rst_n low SHALL force state IDLE, out_valid 0, result 0, zero 1, illegal 0 and clear the multiplier registers, asynchronously.
REQ-028 Reset asserted during MUL or HOLD SHALL discard the operation; no result is produced after release.
REQ-029 in_ready SHALL be high in the first cycle after reset release.

Configuration
REQ-030 Macro SIMD_ALU_SAT_EN: when defined, ops 1010/1011 clamp each lane to [-2^(L-1), 2^(L-1)-1].
REQ-031 Without SIMD_ALU_SAT_EN, ops 1010/1011 SHALL be illegal per REQ-018, and no saturation logic is built.

Verification
REQ-032 Mode 01 add, a=0x7F80FF01, b=0x01800102, out_ready=1 -> one cycle later result=0x80000003, zero=0, illegal=0.
REQ-033 Mode 10 mul-low, a=0x00030100, b=0x00050100 -> in_ready low 16 cycles, then result=0x000F0000, out_valid high.
REQ-034 Mode 01 sat-add with SIMD_ALU_SAT_EN, a=0x7F80107F, b=0x01FF1001 -> result=0x7F80207F; without macro -> result=0, illegal=1.
REQ-035 Mode 00 sub, a=b=0x12345678, out_ready=0 for 5 cycles -> result=0, zero=1 held stable, in_ready low until out_ready=1.
REQ-036 Reset pulsed during scalar mul-low -> out_valid stays 0, result=0; in_ready=1 on the first post-release cycle.
REQ-037 Mode 11 op 0000 -> result=0, zero=1, illegal=1, latency 1.
